ad9767_rx: RTL and testbench

AD9767_RX -- requirements
Module: ad9767_rx

---
 rtl/ad9767_rx.sv | 185 ++++++++++++++++++
 tb/tb_ad9767_rx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ad9767_rx.sv
// ad9767_rx: captures words from an AD9767-style DAC bus into the i_clk domain.
// A two-flop synchronizer feeds edge detection on i_dac_clk. Each detected edge
// pushes one captured word into a small first-word-fall-through FIFO. A link FSM
// tracks the lock state from the gap between detected edges.
// Optional build macro: AD9767_RX_PERIOD_MEAS_EN adds the edge-to-edge period
// measurement (o_period / o_period_vld). Without it those outputs are tied to 0.
module ad9767_rx #(
    parameter int unsigned DATA_W  = 14,
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_dac_clk,
    input  logic [DATA_W-1:0] i_dac_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_overflow,
    output logic              o_locked,
    output logic [7:0]        o_period,
    output logic              o_period_vld
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned PW    = FIFO_AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_LOST   = 2'd2
    } state_e;

    // Synchronizers and edge history
    logic              dclk_s1_q, dclk_s2_q, dclk_prev_q;
    logic [DATA_W-1:0] data_s1_q, data_s2_q;
    logic              detect_c;

    // FIFO storage and pointers (extra MSB separates full from empty)
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic              full_c, pop_c, push_c, drop_c;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ovf_q, ovf_d;

    // Link tracking
    state_e            state_q, state_d;
    logic [7:0]        gap_q, gap_d;
    logic              locked_q, locked_d;

    assign detect_c = dclk_s2_q & ~dclk_prev_q;

    // Capture the DAC clock and data through identical two-flop chains
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dclk_s1_q   <= 1'b0;
            dclk_s2_q   <= 1'b0;
            dclk_prev_q <= 1'b0;
            data_s1_q   <= '0;
            data_s2_q   <= '0;
        end else begin
            dclk_s1_q   <= i_dac_clk;
            dclk_s2_q   <= dclk_s1_q;
            dclk_prev_q <= dclk_s2_q;
            data_s1_q   <= i_dac_data;
            data_s2_q   <= data_s1_q;
        end
    end

    // FIFO control: a pop frees a slot before the push is judged, so push+pop never drops
    always_comb begin
        full_c  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                  (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
        pop_c   = valid_q & i_ready;
        push_c  = detect_c & (~full_c | pop_c);
        drop_c  = detect_c & full_c & ~pop_c;
        rptr_d  = rptr_q + PW'(pop_c);
        wptr_d  = wptr_q + PW'(push_c);
        ovf_d   = ovf_q | drop_c;
        // Head view uses the pre-push write pointer: a new word shows one cycle after its write
        valid_d = (wptr_q != rptr_d);
        data_d  = mem_q[rptr_d[FIFO_AW-1:0]];
    end

    // FIFO storage write; contents need no reset since pointers define validity
    always_ff @(posedge i_clk) begin
        if (push_c) begin
            mem_q[wptr_q[FIFO_AW-1:0]] <= data_s2_q;
        end
    end

    // FIFO pointers and registered head outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    // Link FSM next state, gap counter and lock flag
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        locked_d = 1'b0;
        if (detect_c) begin
            gap_d = 8'd0;
        end else if (gap_q != 8'hFF) begin
            gap_d = gap_q + 8'd1;
        end
        case (state_q)
            ST_IDLE: begin
                if (detect_c) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (!detect_c && (gap_d == 8'(TIMEOUT))) state_d = ST_LOST;
            end
            ST_LOST: begin
                if (detect_c) state_d = ST_LOCKED;
            end
            default: state_d = ST_IDLE;
        endcase
        locked_d = (state_d == ST_LOCKED);
    end

    // Link FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            gap_q    <= 8'd0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            locked_q <= locked_d;
        end
    end

`ifdef AD9767_RX_PERIOD_MEAS_EN
    logic [7:0] period_q, period_d;
    logic       pvld_q, pvld_d;

    // Period = cycles between this edge and the previous one; the first edge after reset has no reference
    always_comb begin
        period_d = period_q;
        pvld_d   = 1'b0;
        if (detect_c && (state_q != ST_IDLE)) begin
            period_d = (gap_q == 8'hFF) ? 8'hFF : gap_q + 8'd1;
            pvld_d   = 1'b1;
        end
    end

    // Period measurement registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            period_q <= 8'd0;
            pvld_q   <= 1'b0;
        end else begin
            period_q <= period_d;
            pvld_q   <= pvld_d;
        end
    end

    assign o_period     = period_q;
    assign o_period_vld = pvld_q;
`else
    assign o_period     = 8'd0;
    assign o_period_vld = 1'b0;
`endif

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_overflow = ovf_q;
    assign o_locked   = locked_q;

endmodule

// File: tb/tb_ad9767_rx.sv
// Testbench for ad9767_rx: directed scenarios plus a randomized phase, all
// checked every cycle against a transaction-level reference model.
module tb_ad9767_rx;

    localparam int unsigned DW      = 14;
    localparam int unsigned TMO     = 200;
    localparam int unsigned AW      = 2;
    localparam int unsigned DEPTH   = 1 << AW;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_dac_clk = 1'b0;
    logic [DW-1:0] i_dac_data = '0;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic          o_overflow;
    logic          o_locked;
    logic [7:0]    o_period;
    logic          o_period_vld;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          rnd_ready = 1'b0;

    ad9767_rx #(.DATA_W(DW), .TIMEOUT(TMO), .FIFO_AW(AW)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_dac_clk    (i_dac_clk),
        .i_dac_data   (i_dac_data),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_overflow   (o_overflow),
        .o_locked     (o_locked),
        .o_period     (o_period),
        .o_period_vld (o_period_vld)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n cycles, driving just after each rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
            if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // One DAC cycle: data set one cycle ahead of the rise, held through the cycle
    task automatic dac_edge(input logic [DW-1:0] d, input int hi, input int lo);
        i_dac_data = d;
        tick(1);
        i_dac_clk = 1'b1;
        tick(hi);
        i_dac_clk = 1'b0;
        tick(lo);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick(2);
        i_rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned   due;
        logic [DW-1:0] d;
    } pend_t;

    pend_t         pend_q[$];
    logic [DW-1:0] exp_q[$];
    int unsigned   ecnt = 0;
    int unsigned   since = 0;
    bit            prev_smp = 1'b0;
    bit            seen = 1'b0;
    bit            m_vld = 1'b0;
    bit            m_ovf = 1'b0;
    bit            m_pvld = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic [7:0]    m_period = 8'd0;

    // Model: a DAC rise sampled at edge k is queued at edge k+2 and visible one cycle later;
    // consumer pops go first, so a push only drops when the queue is still full.
    initial begin : model
        bit            s_rst, s_clk, s_rdy, nv, m_lock;
        logic [DW-1:0] s_d, nd;
        pend_t         p;
        forever begin
            @(posedge i_clk);
            s_rst = i_rst; s_clk = i_dac_clk; s_d = i_dac_data; s_rdy = i_ready;
            ecnt++;
            if (s_rst) begin
                pend_q.delete(); exp_q.delete();
                prev_smp = 1'b0; seen = 1'b0; since = 0;
                m_vld = 1'b0; m_ovf = 1'b0; m_pvld = 1'b0; m_period = 8'd0;
            end else begin
                m_pvld = 1'b0;
                if (m_vld && s_rdy) void'(exp_q.pop_front());
                nv = (exp_q.size() > 0);
                nd = nv ? exp_q[0] : '0;
                if (since < 100000) since++;
                if (pend_q.size() > 0 && pend_q[0].due == ecnt) begin
                    p = pend_q.pop_front();
                    if (exp_q.size() == DEPTH) m_ovf = 1'b1;
                    else exp_q.push_back(p.d);
                    if (seen) begin
                        m_period = (since >= 255) ? 8'd255 : 8'(since);
                        m_pvld = 1'b1;
                    end
                    seen = 1'b1;
                    since = 0;
                end
                if (s_clk && !prev_smp) pend_q.push_back('{ecnt + 2, s_d});
                prev_smp = s_clk;
                m_vld = nv;
                m_data = nd;
            end
            m_lock = seen && (since < TMO);
            @(negedge i_clk);
            check_eq("valid", 32'(o_valid), 32'(m_vld));
            if (m_vld) check_eq("data", 32'(o_data), 32'(m_data));
            check_eq("overflow", 32'(o_overflow), 32'(m_ovf));
            check_eq("locked", 32'(o_locked), 32'(m_lock));
`ifdef AD9767_RX_PERIOD_MEAS_EN
            check_eq("period", 32'(o_period), 32'(m_period));
            check_eq("period_vld", 32'(o_period_vld), 32'(m_pvld));
`else
            check_eq("period_off", 32'(o_period), 32'd0);
            check_eq("period_vld_off", 32'(o_period_vld), 32'd0);
`endif
        end
    end

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        tick(3);
        i_rst = 1'b0;
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_data", 32'(o_data), 32'd0);
        check_eq("rst_locked", 32'(o_locked), 32'd0);
        check_eq("rst_ovf", 32'(o_overflow), 32'd0);
        check_eq("rst_period", 32'(o_period), 32'd0);

        // Steady 64-cycle DAC clock, alternating data, consumer always ready
        i_ready = 1'b1;
        for (int i = 0; i < 8; i++) dac_edge((i % 2 == 0) ? 14'h2000 : 14'h0000, 32, 31);
        check_eq("s37_locked", 32'(o_locked), 32'd1);

        // Stalled consumer: 6 words into a 4-deep FIFO, then drain
        do_reset();
        i_ready = 1'b0;
        for (int i = 0; i < 6; i++) dac_edge(14'(16'h0100 + i), 4, 5);
        check_eq("s38_ovf", 32'(o_overflow), 32'd1);
        check_eq("s38_valid", 32'(o_valid), 32'd1);
        check_eq("s38_head", 32'(o_data), 32'h0100);
        i_ready = 1'b1;
        tick(10);
        check_eq("s38_drained", 32'(o_valid), 32'd0);

        // Full FIFO with a pop landing on the same cycle as a push
        do_reset();
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) dac_edge(14'(16'h0A00 + i), 4, 5);
        i_dac_data = 14'h0A55;
        tick(1);
        i_dac_clk = 1'b1;
        tick(2);
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        tick(3);
        i_dac_clk = 1'b0;
        tick(5);
        check_eq("s39_ovf", 32'(o_overflow), 32'd0);
        check_eq("s39_head", 32'(o_data), 32'h0A01);
        i_ready = 1'b1;
        tick(10);

        // Randomized data, periods and consumer
        do_reset();
        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++)
            dac_edge(14'($urandom), $urandom_range(4, 10), $urandom_range(3, 12));
        rnd_ready = 1'b0;
        i_ready = 1'b1;
        tick(10);

        // Clock loss and relock
        do_reset();
        for (int i = 0; i < 3; i++) dac_edge(14'(16'h0300 + i), 5, 6);
        tick(300);
        check_eq("s40_lost", 32'(o_locked), 32'd0);
        dac_edge(14'h0333, 5, 6);
        check_eq("s40_relock", 32'(o_locked), 32'd1);

        // Reset with words queued
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) dac_edge(14'(16'h0400 + i), 4, 5);
        i_rst = 1'b1;
        tick(1);
        check_eq("s41_valid", 32'(o_valid), 32'd0);
        i_rst = 1'b0;
        i_ready = 1'b1;
        dac_edge(14'h0444, 5, 6);
        dac_edge(14'h0555, 5, 6);
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
